// File: rtl/iq_oldest_ready_select.sv
// Oldest-ready selector for the FIFO dequeue side, feeding a 2-entry skid
// buffer towards the issue stage. Selection is combinational; the skid buffer
// isolates the FIFO handshake from downstream issue_ready.
module iq_oldest_ready_select #(
  parameter int N_ENTRIES       = 8,
  parameter int ENTRY_WIDTH     = 32,
  parameter int READY_BIT       = 0,
  parameter int CTR_WIDTH       = $clog2(N_ENTRIES) + 1,
  parameter int ISSUE_CNT_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_aL,
  input  logic                             flush,
  input  logic [CTR_WIDTH-1:0]             entry_count,
  input  logic [N_ENTRIES*ENTRY_WIDTH-1:0] entry_douts,
  input  logic                             deq_valid,
  input  logic [ENTRY_WIDTH-1:0]           deq_data,
  output logic                             deq_ready,
  output logic [N_ENTRIES-1:0]             deq_sel_onehot,
  output logic                             issue_valid,
  output logic [ENTRY_WIDTH-1:0]           issue_data,
  input  logic                             issue_ready,
  output logic [ISSUE_CNT_WIDTH-1:0]       issue_count,
  output logic [1:0]                       occupancy
);

  logic [N_ENTRIES-1:0]   cand;
  logic [ENTRY_WIDTH-1:0] slot0;
  logic [ENTRY_WIDTH-1:0] slot1;
  logic                   push;
  logic                   pop;
  logic                   unused_entry_bits;

  // Only the ready bit of each entry matters here; the payload arrives on deq_data.
  assign unused_entry_bits = ^entry_douts;

  // Candidate vector: valid entry (index below entry_count) with ready bit set.
  always_comb begin
    cand = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      cand[i] = (CTR_WIDTH'(i) < entry_count) && entry_douts[i*ENTRY_WIDTH + READY_BIT];
    end
  end

  // Lowest set bit of cand is the oldest ready entry (two's-complement isolate).
  assign deq_sel_onehot = cand & (~cand + N_ENTRIES'(1));

  // Handshake uses only registered occupancy, flush and entry inputs.
  assign deq_ready   = rst_aL && (|cand) && (occupancy != 2'd2) && !flush;
  assign push        = deq_valid && deq_ready;
  assign issue_valid = (occupancy != 2'd0);
  assign issue_data  = slot0;
  assign pop         = issue_valid && issue_ready;

  // Skid buffer: slot0 is the head, slot1 is only occupied at fill level 2.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      occupancy <= 2'd0;
      slot0     <= '0;
      slot1     <= '0;
    end else if (flush) begin
      occupancy <= 2'd0;
      slot0     <= '0;
      slot1     <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occupancy == 2'd0) slot0 <= deq_data;
          else                   slot1 <= deq_data;
          occupancy <= occupancy + 2'd1;
        end
        2'b01: begin
          slot0     <= slot1;
          slot1     <= '0;
          occupancy <= occupancy - 2'd1;
        end
        // Push only happens below level 2 and pop needs level >= 1, so the
        // simultaneous case is always level 1: the new entry replaces the head.
        2'b11: slot0 <= deq_data;
        default: ;
      endcase
    end
  end

  // Issued-entry counter; pops during a flush cycle still count.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      issue_count <= '0;
    end else if (pop) begin
      issue_count <= issue_count + ISSUE_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_iq_oldest_ready_select.sv
// Self-checking bench for iq_oldest_ready_select: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_iq_oldest_ready_select;

  localparam int N  = 8;
  localparam int EW = 32;
  localparam int RB = 0;
  localparam int CW = 4;
  localparam int IW = 16;

  logic            clk;
  logic            rst_aL;
  logic            flush;
  logic [CW-1:0]   entry_count;
  logic [N*EW-1:0] entry_douts;
  logic            deq_valid;
  logic [EW-1:0]   deq_data;
  logic            deq_ready;
  logic [N-1:0]    deq_sel_onehot;
  logic            issue_valid;
  logic [EW-1:0]   issue_data;
  logic            issue_ready;
  logic [IW-1:0]   issue_count;
  logic [1:0]      occupancy;

  int passed = 0;
  int total  = 0;

  iq_oldest_ready_select #(
    .N_ENTRIES(N), .ENTRY_WIDTH(EW), .READY_BIT(RB), .CTR_WIDTH(CW), .ISSUE_CNT_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_aL(rst_aL), .flush(flush), .entry_count(entry_count),
    .entry_douts(entry_douts), .deq_valid(deq_valid), .deq_data(deq_data),
    .deq_ready(deq_ready), .deq_sel_onehot(deq_sel_onehot), .issue_valid(issue_valid),
    .issue_data(issue_data), .issue_ready(issue_ready), .issue_count(issue_count),
    .occupancy(occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: skid buffer contents as a queue, counter as an integer.
  logic [EW-1:0] mq[$];
  int unsigned   m_cnt;

  function automatic int oldest_ready();
    for (int i = 0; i < int'(entry_count); i++)
      if (i < N && entry_douts[i*EW + RB]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_sel();
    int idx = oldest_ready();
    logic [N-1:0] s = '0;
    if (idx >= 0) s[idx] = 1'b1;
    return s;
  endfunction

  function automatic logic exp_ready();
    return rst_aL && (oldest_ready() >= 0) && (mq.size() < 2) && !flush;
  endfunction

  always @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      logic do_pop, do_fire;
      do_pop  = (mq.size() != 0) && issue_ready;
      do_fire = deq_valid && exp_ready();
      if (do_pop) begin
        void'(mq.pop_front());
        m_cnt = (m_cnt + 1) % (1 << IW);
      end
      if (flush) mq.delete();
      else if (do_fire) mq.push_back(deq_data);
    end
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    check("sel", 64'(deq_sel_onehot), 64'(exp_sel()));
    check("deq_ready", 64'(deq_ready), 64'(exp_ready()));
    check("issue_valid", 64'(issue_valid), 64'(mq.size() != 0));
    check("occupancy", 64'(occupancy), 64'(mq.size()));
    check("issue_count", 64'(issue_count), 64'(m_cnt));
    if (mq.size() != 0) check("issue_data", 64'(issue_data), 64'(mq[0]));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_aL      = 1'b0;
    flush       = 1'b0;
    entry_count = 4'd1;
    entry_douts = {N{32'h0000_0001}};
    deq_valid   = 1'b1;
    deq_data    = 32'h1234_5678;
    issue_ready = 1'b0;
    tick();
    tick();
    #1;
    check("rst_valid", 64'(issue_valid), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_cnt", 64'(issue_count), 64'd0);
    check("rst_data", 64'(issue_data), 64'd0);
    check("rst_deq_ready", 64'(deq_ready), 64'd0);
    rst_aL = 1'b1;
    deq_valid = 1'b0;
    tick();

    // Oldest-ready pick: e0 not ready, e1 and e2 ready.
    entry_count = 4'd3;
    entry_douts = '0;
    entry_douts[0*EW +: EW] = 32'h0000_1110;
    entry_douts[1*EW +: EW] = 32'hDEAD_0001;
    entry_douts[2*EW +: EW] = 32'h0000_0003;
    deq_valid   = 1'b1;
    deq_data    = 32'hDEAD_0001;
    issue_ready = 1'b1;
    #1;
    check("pick_sel", 64'(deq_sel_onehot), 64'h02);
    check("pick_ready", 64'(deq_ready), 64'd1);
    tick();
    deq_valid = 1'b0;
    #1;
    check("pick_valid", 64'(issue_valid), 64'd1);
    check("pick_data", 64'(issue_data), 64'hDEAD_0001);
    tick();

    // Stale ready bits beyond entry_count.
    entry_count = 4'd0;
    entry_douts = {N{32'hFFFF_FFFF}};
    deq_valid   = 1'b1;
    #1;
    check("stale_sel", 64'(deq_sel_onehot), 64'd0);
    check("stale_ready", 64'(deq_ready), 64'd0);
    tick();

    // Backpressure: two fires then stall.
    entry_count = 4'd2;
    issue_ready = 1'b0;
    deq_data    = 32'hA000_0001;
    tick();
    deq_data    = 32'hA000_0002;
    tick();
    #1;
    check("bp_occ", 64'(occupancy), 64'd2);
    check("bp_ready", 64'(deq_ready), 64'd0);
    check("bp_head", 64'(issue_data), 64'hA000_0001);
    deq_data    = 32'hA000_0003;
    issue_ready = 1'b1;
    tick();
    #1;
    check("bp_occ1", 64'(occupancy), 64'd1);
    check("bp_head2", 64'(issue_data), 64'hA000_0002);
    check("bp_reassert", 64'(deq_ready), 64'd1);
    check("bp_cnt", 64'(issue_count), 64'd2);
    // Simultaneous push and pop at occupancy 1.
    tick();
    #1;
    check("pp_occ", 64'(occupancy), 64'd1);
    check("pp_head", 64'(issue_data), 64'hA000_0003);
    check("pp_cnt", 64'(issue_count), 64'd3);
    deq_valid = 1'b0;
    tick();
    #1;
    check("drain_occ", 64'(occupancy), 64'd0);
    check("drain_cnt", 64'(issue_count), 64'd4);

    // Stream until the counter reaches its maximum.
    deq_valid = 1'b1;
    for (int k = 0; k < 70000 && m_cnt != 32'hFFFF; k++) begin
      deq_data = 32'hB000_0000 + 32'(k);
      tick();
    end
    issue_ready = 1'b0;
    tick();
    #1;
    check("wrap_pre_cnt", 64'(issue_count), 64'hFFFF);
    check("wrap_pre_occ", 64'(occupancy), 64'd2);
    flush       = 1'b1;
    issue_ready = 1'b1;
    #1;
    check("flush_deq_ready", 64'(deq_ready), 64'd0);
    tick();
    #1;
    check("flush_cnt", 64'(issue_count), 64'd0);
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_valid", 64'(issue_valid), 64'd0);
    flush = 1'b0;

    // Asynchronous reset mid-cycle while full.
    issue_ready = 1'b0;
    deq_data    = 32'hC000_0001;
    tick();
    deq_data    = 32'hC000_0002;
    tick();
    #1;
    check("prerst_occ", 64'(occupancy), 64'd2);
    rst_aL = 1'b0;
    #1;
    check("arst_valid", 64'(issue_valid), 64'd0);
    check("arst_occ", 64'(occupancy), 64'd0);
    check("arst_cnt", 64'(issue_count), 64'd0);
    check("arst_ready", 64'(deq_ready), 64'd0);
    tick();
    rst_aL = 1'b1;
    tick();
    tick();
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
